// File: rtl/logic_shift_unit_if.sv
// ============================================================================
// logic_shift_unit_if : request/result bundle for the logic/shift unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface logic_shift_unit_if #(
    parameter int WORD_SIZE = 16
);
    logic                 start;
    logic [2:0]           op;
    logic                 byte_op;
    logic [WORD_SIZE-1:0] src_a;
    logic [WORD_SIZE-1:0] src_b;
    logic                 carry_in;
    logic                 ready;
    logic                 done;
    logic [WORD_SIZE-1:0] result;
    logic                 carry;
    logic                 zero;
    logic                 neg;

    modport master (
        output start, op, byte_op, src_a, src_b, carry_in,
        input  ready, done, result, carry, zero, neg
    );

    modport slave (
        input  start, op, byte_op, src_a, src_b, carry_in,
        output ready, done, result, carry, zero, neg
    );
endinterface

`default_nettype wire

// File: rtl/logic_shift_unit_m.sv
// ============================================================================
// logic_shift_unit_m : multi-cycle logic / shift unit, one shift bit per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module logic_shift_unit_m #(
    parameter int WORD_SIZE = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    logic_shift_unit_if.slave       bus
);
    localparam int CNT_W = $clog2(WORD_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [2:0]           r_op;
    logic                 r_byte;
    logic [WORD_SIZE-1:0] r_val;
    logic                 r_c;
    logic [CNT_W-1:0]     r_cnt;
    logic [WORD_SIZE-1:0] r_result;
    logic                 r_carry;
    logic                 r_zero;
    logic                 r_neg;

    logic [CNT_W-1:0]     w_cnt_in;
    logic [WORD_SIZE-1:0] w_logic;
    logic [WORD_SIZE-1:0] w_logic_res;
    logic                 w_msb_in;
    logic [WORD_SIZE-1:0] w_step;
    logic                 w_step_c;
    logic                 w_accept;
    logic                 w_quick;
    logic                 w_finish;
    logic                 w_load;
    logic [WORD_SIZE-1:0] w_res_next;
    logic                 w_c_next;
    logic                 w_byte_next;
    logic                 w_zero_next;
    logic                 w_neg_next;

    // Incoming operands: count extraction and single-cycle logic result
    always_comb begin
        w_cnt_in = bus.byte_op ? CNT_W'(bus.src_b[2:0]) : bus.src_b[CNT_W-1:0];
        case (bus.op[1:0])
            2'b00:   w_logic = bus.src_a ^ bus.src_b;
            2'b01:   w_logic = bus.src_a & bus.src_b;
            2'b10:   w_logic = bus.src_a & ~bus.src_b;
            default: w_logic = bus.src_a | bus.src_b;
        endcase
        w_logic_res = bus.byte_op ? {bus.src_a[WORD_SIZE-1:8], w_logic[7:0]} : w_logic;
    end

    // One-bit step of the latched operand; op[1:0]==00 is SLL
    always_comb begin
        case (r_op[1:0])
            2'b10:   w_msb_in = r_byte ? r_val[7] : r_val[WORD_SIZE-1];
            2'b11:   w_msb_in = r_c;
            default: w_msb_in = 1'b0;
        endcase
        if (r_op[1:0] == 2'b00) begin
            w_step_c = r_byte ? r_val[7] : r_val[WORD_SIZE-1];
            w_step   = r_byte ? {r_val[WORD_SIZE-1:8], r_val[6:0], 1'b0}
                              : {r_val[WORD_SIZE-2:0], 1'b0};
        end else begin
            w_step_c = r_val[0];
            w_step   = r_byte ? {r_val[WORD_SIZE-1:8], w_msb_in, r_val[7:1]}
                              : {w_msb_in, r_val[WORD_SIZE-1:1]};
        end
    end

    always_comb begin
        w_accept = (r_state == IDLE) && bus.start;
        w_quick  = !bus.op[2] || (w_cnt_in == '0);
        w_finish = (r_state == SHIFT) && (r_cnt == CNT_W'(1));
        w_load   = (w_accept && w_quick) || w_finish;
        if (w_accept) begin
            w_res_next  = bus.op[2] ? bus.src_a : w_logic_res;
            w_c_next    = bus.carry_in;
            w_byte_next = bus.byte_op;
        end else begin
            w_res_next  = w_step;
            w_c_next    = w_step_c;
            w_byte_next = r_byte;
        end
        w_zero_next = w_byte_next ? (w_res_next[7:0] == 8'd0) : (w_res_next == '0);
        w_neg_next  = w_byte_next ? w_res_next[7] : w_res_next[WORD_SIZE-1];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = w_quick ? DONE : SHIFT;
            SHIFT:   if (r_cnt == CNT_W'(1)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op     <= 3'd0;
            r_byte   <= 1'b0;
            r_val    <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op   <= bus.op;
                r_byte <= bus.byte_op;
                r_val  <= bus.src_a;
                r_c    <= bus.carry_in;
                r_cnt  <= w_cnt_in;
            end else if (r_state == SHIFT) begin
                r_val  <= w_step;
                r_c    <= w_step_c;
                r_cnt  <= r_cnt - CNT_W'(1);
            end
            if (w_load) begin
                r_result <= w_res_next;
                r_carry  <= w_c_next;
                r_zero   <= w_zero_next;
                r_neg    <= w_neg_next;
            end
        end
    end

    assign bus.ready  = (r_state == IDLE);
    assign bus.done   = (r_state == DONE);
    assign bus.result = r_result;
    assign bus.carry  = r_carry;
    assign bus.zero   = r_zero;
    assign bus.neg    = r_neg;

endmodule

`default_nettype wire
